// File: rtl/input_source_arbiter_if.sv
// Bundle for the player-1 input arbiter: three receiver button vectors and a
// manual force select go in; the granted owner, its buttons and a change
// pulse come out.
//   master : drives b_board_in, N64_in, remote_in, force_sel; observes outputs
//   slave  : the arbiter side (consumes inputs, drives owner/buttons_out/owner_changed)
interface input_source_arbiter_if #(
  parameter int unsigned WIDTH = 12
);
  logic [WIDTH-1:0] b_board_in;
  logic [WIDTH-1:0] N64_in;
  logic [WIDTH-1:0] remote_in;
  logic [1:0]       force_sel;
  logic [1:0]       owner;
  logic [WIDTH-1:0] buttons_out;
  logic             owner_changed;

  modport master (
    output b_board_in,
    output N64_in,
    output remote_in,
    output force_sel,
    input  owner,
    input  buttons_out,
    input  owner_changed
  );

  modport slave (
    input  b_board_in,
    input  N64_in,
    input  remote_in,
    input  force_sel,
    output owner,
    output buttons_out,
    output owner_changed
  );
endinterface

// File: rtl/input_source_arbiter.sv
// Arbitrates player-1 ownership among the button board, N64 and remote
// receivers. A source must be active for SETTLE_CYCLES consecutive cycles to
// be granted; the owner is released after IDLE_TIMEOUT consecutive idle
// cycles. A nonzero force_sel overrides arbitration and selects the owner.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : slave side of input_source_arbiter_if (inputs, owner, buttons_out,
//           owner_changed; all outputs registered)
module input_source_arbiter #(
  parameter int unsigned WIDTH         = 12,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned IDLE_TIMEOUT  = 50000,
  parameter int unsigned CNT_W         = 16
) (
  input logic                  clk,
  input logic                  reset,
  input_source_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StClaim, StOwn, StForced} state_e;

  localparam logic [1:0]       SelNone   = 2'b00;
  localparam logic [1:0]       SelBoard  = 2'b01;
  localparam logic [1:0]       SelN64    = 2'b10;
  localparam logic [1:0]       SelRemote = 2'b11;
  localparam logic [CNT_W-1:0] SettleMax = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] IdleMax   = CNT_W'(IDLE_TIMEOUT);

  state_e           r_state, w_state_d;
  logic [1:0]       r_cand, w_cand_d;
  logic [1:0]       r_owner, w_owner_d;
  logic [CNT_W-1:0] r_settle_cnt, w_settle_d;
  logic [CNT_W-1:0] r_idle_cnt, w_idle_d;
  logic [WIDTH-1:0] r_buttons, w_buttons_d;
  logic             r_owner_changed;

  logic [WIDTH-1:0] w_owner_src;
  logic [WIDTH-1:0] w_cand_src;
  logic [1:0]       w_prio_sel;
  logic             w_any_active;
  logic [CNT_W-1:0] w_settle_inc;
  logic [CNT_W-1:0] w_idle_inc;

  // Source muxes; select 00 yields an all-zero vector.
  always_comb begin
    w_owner_src = '0;
    unique case (r_owner)
      SelBoard:  w_owner_src = bus.b_board_in;
      SelN64:    w_owner_src = bus.N64_in;
      SelRemote: w_owner_src = bus.remote_in;
      default:   w_owner_src = '0;
    endcase
  end

  always_comb begin
    w_cand_src = '0;
    unique case (r_cand)
      SelBoard:  w_cand_src = bus.b_board_in;
      SelN64:    w_cand_src = bus.N64_in;
      SelRemote: w_cand_src = bus.remote_in;
      default:   w_cand_src = '0;
    endcase
  end

  // Fixed priority: button board > N64 > remote.
  always_comb begin
    w_prio_sel = SelRemote;
    if (|bus.b_board_in) begin
      w_prio_sel = SelBoard;
    end else if (|bus.N64_in) begin
      w_prio_sel = SelN64;
    end
  end

  assign w_any_active = (|bus.b_board_in) | (|bus.N64_in) | (|bus.remote_in);

  // Saturating increments so the counters never wrap.
  assign w_settle_inc = (r_settle_cnt == '1) ? r_settle_cnt : r_settle_cnt + 1'b1;
  assign w_idle_inc   = (r_idle_cnt == '1) ? r_idle_cnt : r_idle_cnt + 1'b1;

  always_comb begin
    w_state_d  = r_state;
    w_cand_d   = r_cand;
    w_owner_d  = r_owner;
    w_settle_d = r_settle_cnt;
    w_idle_d   = r_idle_cnt;

    if (bus.force_sel != SelNone) begin
      // Force beats every automatic transition in the same cycle.
      w_state_d  = StForced;
      w_owner_d  = bus.force_sel;
      w_cand_d   = SelNone;
      w_settle_d = '0;
      w_idle_d   = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_owner_d  = SelNone;
          w_settle_d = '0;
          w_idle_d   = '0;
          if (w_any_active) begin
            w_cand_d = w_prio_sel;
            if (SETTLE_CYCLES <= 1) begin
              w_state_d = StOwn;
              w_owner_d = w_prio_sel;
            end else begin
              w_state_d  = StClaim;
              w_settle_d = CNT_W'(1);
            end
          end
        end
        StClaim: begin
          if (w_cand_src == '0) begin
            w_state_d  = StIdle;
            w_settle_d = '0;
          end else if (w_settle_inc >= SettleMax) begin
            w_state_d  = StOwn;
            w_owner_d  = r_cand;
            w_settle_d = '0;
          end else begin
            w_settle_d = w_settle_inc;
          end
        end
        StOwn: begin
          if (w_owner_src != '0) begin
            w_idle_d = '0;
          end else if (w_idle_inc >= IdleMax) begin
            w_state_d = StIdle;
            w_owner_d = SelNone;
            w_cand_d  = SelNone;
            w_idle_d  = '0;
          end else begin
            w_idle_d = w_idle_inc;
          end
        end
        StForced: begin
          w_state_d  = StIdle;
          w_owner_d  = SelNone;
          w_settle_d = '0;
          w_idle_d   = '0;
        end
        default: begin
          w_state_d  = StIdle;
          w_owner_d  = SelNone;
          w_settle_d = '0;
          w_idle_d   = '0;
        end
      endcase
    end

    // One-cycle latency from the current owner's input; zero whenever the
    // next owner is none so release and buttons clear on the same edge.
    w_buttons_d = (w_owner_d == SelNone) ? '0 : w_owner_src;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= StIdle;
      r_cand          <= SelNone;
      r_owner         <= SelNone;
      r_settle_cnt    <= '0;
      r_idle_cnt      <= '0;
      r_buttons       <= '0;
      r_owner_changed <= 1'b0;
    end else begin
      r_state         <= w_state_d;
      r_cand          <= w_cand_d;
      r_owner         <= w_owner_d;
      r_settle_cnt    <= w_settle_d;
      r_idle_cnt      <= w_idle_d;
      r_buttons       <= w_buttons_d;
      r_owner_changed <= (w_owner_d != r_owner);
    end
  end

  assign bus.owner         = r_owner;
  assign bus.buttons_out   = r_buttons;
  assign bus.owner_changed = r_owner_changed;

endmodule

// File: tb/tb_input_source_arbiter.sv
module tb_input_source_arbiter;

  typedef struct {
    string       name;
    logic [1:0]  owner;
    logic [11:0] btn;
    logic        chg;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  input_source_arbiter_if #(.WIDTH(12)) bus ();

  input_source_arbiter #(
    .WIDTH(12),
    .SETTLE_CYCLES(3),
    .IDLE_TIMEOUT(8),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: outputs are sampled 1 time unit after every rising edge and
  // compared with the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.name, ".owner"}, {10'd0, bus.owner}, {10'd0, e.owner});
        chk({e.name, ".buttons"}, bus.buttons_out, e.btn);
        chk({e.name, ".changed"}, {11'd0, bus.owner_changed}, {11'd0, e.chg});
      end
    end
  end

  // Drive one cycle of inputs and queue the values expected after the next edge.
  task automatic step(input string nm, input logic [11:0] b, input logic [11:0] n,
                      input logic [11:0] r, input logic [1:0] f, input logic [1:0] eo,
                      input logic [11:0] eb, input logic ec);
    exp_t e;
    @(negedge clk);
    bus.b_board_in = b;
    bus.N64_in     = n;
    bus.remote_in  = r;
    bus.force_sel  = f;
    e.name  = nm;
    e.owner = eo;
    e.btn   = eb;
    e.chg   = ec;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    bus.b_board_in = '0;
    bus.N64_in     = '0;
    bus.remote_in  = '0;
    bus.force_sel  = '0;
    #12;
    chk("reset.owner", {10'd0, bus.owner}, 12'd0);
    chk("reset.buttons", bus.buttons_out, 12'd0);
    chk("reset.changed", {11'd0, bus.owner_changed}, 12'd0);
    @(negedge clk);
    reset = 1'b1;

    // Claim by button board after three active cycles.
    step("t1_e1", 12'h010, 12'h0, 12'h0, 2'b00, 2'b00, 12'h000, 1'b0);
    step("t1_e2", 12'h010, 12'h0, 12'h0, 2'b00, 2'b00, 12'h000, 1'b0);
    step("t1_e3", 12'h010, 12'h0, 12'h0, 2'b00, 2'b01, 12'h000, 1'b1);
    step("t1_e4", 12'h010, 12'h0, 12'h0, 2'b00, 2'b01, 12'h010, 1'b0);
    step("t1_e5", 12'h010, 12'h0, 12'h0, 2'b00, 2'b01, 12'h010, 1'b0);

    // Owner idle while remote is busy: remote ignored, idle count keeps going.
    for (int i = 0; i < 5; i++) step("t4_ign", 12'h0, 12'h0, 12'hFFF, 2'b00, 2'b01, 12'h0, 1'b0);
    for (int i = 0; i < 2; i++) step("t4_idle", 12'h0, 12'h0, 12'h0, 2'b00, 2'b01, 12'h0, 1'b0);
    step("t4_tmo", 12'h0, 12'h0, 12'h0, 2'b00, 2'b00, 12'h0, 1'b1);

    // N64 wins priority, aborts, then remote claims.
    step("t2_e1", 12'h0, 12'h001, 12'h002, 2'b00, 2'b00, 12'h000, 1'b0);
    step("t2_e2", 12'h0, 12'h001, 12'h002, 2'b00, 2'b00, 12'h000, 1'b0);
    step("t2_e3", 12'h0, 12'h000, 12'h002, 2'b00, 2'b00, 12'h000, 1'b0);
    step("t2_e4", 12'h0, 12'h000, 12'h002, 2'b00, 2'b00, 12'h000, 1'b0);
    step("t2_e5", 12'h0, 12'h000, 12'h002, 2'b00, 2'b00, 12'h000, 1'b0);
    step("t2_e6", 12'h0, 12'h000, 12'h002, 2'b00, 2'b11, 12'h000, 1'b1);
    step("t2_e7", 12'h0, 12'h000, 12'h002, 2'b00, 2'b11, 12'h002, 1'b0);
    for (int i = 0; i < 7; i++) step("t2_rel", 12'h0, 12'h0, 12'h0, 2'b00, 2'b11, 12'h0, 1'b0);
    step("t2_tmo", 12'h0, 12'h0, 12'h0, 2'b00, 2'b00, 12'h0, 1'b1);

    // Timeout with a pulse in the middle that restarts the idle count.
    step("t3_e1", 12'h0, 12'h080, 12'h0, 2'b00, 2'b00, 12'h000, 1'b0);
    step("t3_e2", 12'h0, 12'h080, 12'h0, 2'b00, 2'b00, 12'h000, 1'b0);
    step("t3_e3", 12'h0, 12'h080, 12'h0, 2'b00, 2'b10, 12'h000, 1'b1);
    step("t3_e4", 12'h0, 12'h080, 12'h0, 2'b00, 2'b10, 12'h080, 1'b0);
    for (int i = 0; i < 7; i++) step("t3_gap1", 12'h0, 12'h0, 12'h0, 2'b00, 2'b10, 12'h0, 1'b0);
    step("t3_pulse", 12'h0, 12'h080, 12'h0, 2'b00, 2'b10, 12'h080, 1'b0);
    for (int i = 0; i < 7; i++) step("t3_gap2", 12'h0, 12'h0, 12'h0, 2'b00, 2'b10, 12'h0, 1'b0);
    step("t3_tmo", 12'h0, 12'h0, 12'h0, 2'b00, 2'b00, 12'h0, 1'b1);

    // Force during CLAIM, switch forced source, release.
    step("t5_claim", 12'h0, 12'h0A5, 12'h000, 2'b00, 2'b00, 12'h000, 1'b0);
    step("t5_f10", 12'h0, 12'h0A5, 12'h000, 2'b10, 2'b10, 12'h000, 1'b1);
    step("t5_hold", 12'h0, 12'h0A5, 12'h000, 2'b10, 2'b10, 12'h0A5, 1'b0);
    step("t5_f11", 12'h0, 12'h0A5, 12'h3C3, 2'b11, 2'b11, 12'h0A5, 1'b1);
    step("t5_f11b", 12'h0, 12'h0A5, 12'h3C3, 2'b11, 2'b11, 12'h3C3, 1'b0);
    step("t5_rel", 12'h0, 12'h000, 12'h000, 2'b00, 2'b00, 12'h000, 1'b1);
    step("t5_idle", 12'h0, 12'h000, 12'h000, 2'b00, 2'b00, 12'h000, 1'b0);

    // Asynchronous reset while owning.
    step("t6_e1", 12'h010, 12'h0, 12'h0, 2'b00, 2'b00, 12'h000, 1'b0);
    step("t6_e2", 12'h010, 12'h0, 12'h0, 2'b00, 2'b00, 12'h000, 1'b0);
    step("t6_e3", 12'h010, 12'h0, 12'h0, 2'b00, 2'b01, 12'h000, 1'b1);
    step("t6_e4", 12'h010, 12'h0, 12'h0, 2'b00, 2'b01, 12'h010, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_async.owner", {10'd0, bus.owner}, 12'd0);
    chk("t6_async.buttons", bus.buttons_out, 12'd0);
    chk("t6_async.changed", {11'd0, bus.owner_changed}, 12'd0);
    @(negedge clk);
    bus.b_board_in = '0;
    @(negedge clk);
    reset = 1'b1;
    step("t6_post1", 12'h000, 12'h0, 12'h0, 2'b00, 2'b00, 12'h000, 1'b0);
    step("t6_post2", 12'h010, 12'h0, 12'h0, 2'b00, 2'b00, 12'h000, 1'b0);
    step("t6_post3", 12'h010, 12'h0, 12'h0, 2'b00, 2'b00, 12'h000, 1'b0);
    step("t6_post4", 12'h010, 12'h0, 12'h0, 2'b00, 2'b01, 12'h000, 1'b1);

    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
